// File: rtl/ext_int_ctrl.sv
// ext_int_ctrl: initiator side of the external-interrupt request interface.
// Peripheral IRQ lines are synchronised, latched as pending, and arbitrated
// with fixed priority (lowest index wins). The winner is presented to the
// interrupt core on int_sign_external/int_num_external. The core's accept
// (la_ta_ask) and handler-entry (intering) signals are then tracked, and the
// source is retired only after the vector has been fetched.
//
// Optional build macro EXT_INT_CTRL_PREEMPT_EN: while a request waits for
// acceptance, a newly eligible higher-priority source replaces the granted one
// without dropping int_sign_external.
module ext_int_ctrl #(
  parameter int         N_SRC       = 8,
  parameter logic [7:0] NUM_BASE    = 8'h20,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] edge_sel,
  input  logic [N_SRC-1:0] int_mask,
  input  logic             la_ta_ask,
  input  logic             intering,
  output logic             int_sign_external,
  output logic [7:0]       int_num_external,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] in_service
);

  localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_ACCEPTED,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [7:0]       num_q, num_d;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] dly_q;
  logic [N_SRC-1:0] pend_q, pend_d;

  logic [N_SRC-1:0] irq_sync;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] grant_oh;
  logic [N_SRC-1:0] retire_clr;
  logic             retire;
  logic             win_vld;
  logic [GW-1:0]    win_idx;

  // Synchroniser chain on the raw lines plus one delayed copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of flops, not a RAM, so it is reset;
      // a stale 1 left in the chain would otherwise fake a rising edge.
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      dly_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign irq_sync = sync_q[SYNC_STAGES-1];
  assign rise     = irq_sync & ~dly_q;
  assign eligible = pend_q & ~int_mask;

  // Fixed-priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    // NOTE: defaults first so no path through the loop leaves a latch.
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_vld = 1'b1;
        win_idx = GW'(i);
      end
    end
  end

  // One-hot decode of the current grant.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_SRC; i++) begin
      grant_oh[i] = (grant_q == GW'(i));
    end
  end

  // Retirement clears only an edge-triggered granted source; a fresh edge on
  // the same source in the same cycle re-sets it (set wins over clear).
  assign retire     = (state_q == S_ACCEPTED) && intering;
  assign retire_clr = retire ? (grant_oh & edge_sel) : '0;
  assign pend_d     = (edge_sel & ((pend_q & ~retire_clr) | rise)) |
                      (~edge_sel & irq_sync);

  // Pending register: latched edges, or the registered synchronised level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Handshake state, grant and interrupt number registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      num_q   <= num_d;
    end
  end

  // Next-state logic for the request/accept/service/gap handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    num_d   = num_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          num_d   = NUM_BASE + 8'(win_idx);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Once raised the request is committed: masking or a level drop of
        // the granted source does not withdraw it.
        if (la_ta_ask) begin
          state_d = S_ACCEPTED;
        end
`ifdef EXT_INT_CTRL_PREEMPT_EN
        else if (win_vld && (win_idx < grant_q)) begin
          grant_d = win_idx;
          num_d   = NUM_BASE + 8'(win_idx);
        end
`endif
      end
      S_ACCEPTED: begin
        if (intering) begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // One idle cycle so the core sees the request low before a re-request.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign int_sign_external = (state_q == S_REQ);
  assign int_num_external  = num_q;
  assign in_service        = (state_q == S_ACCEPTED) ? grant_oh : '0;
  assign pending           = pend_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Testbench for ext_int_ctrl: directed scenarios with literal expectations,
// plus a cycle model of the request protocol compared on every falling edge.
module tb_ext_int_ctrl;

  localparam int         N    = 8;
  localparam int         SYNC = 2;
  localparam logic [7:0] BASE = 8'h20;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq_in, edge_sel, int_mask;
  logic         la_ta_ask, intering;
  logic         sign;
  logic [7:0]   num;
  logic [N-1:0] pending, in_service;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  ext_int_ctrl #(
    .N_SRC      (N),
    .NUM_BASE   (BASE),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .irq_in           (irq_in),
    .edge_sel         (edge_sel),
    .int_mask         (int_mask),
    .la_ta_ask        (la_ta_ask),
    .intering         (intering),
    .int_sign_external(sign),
    .int_num_external (num),
    .pending          (pending),
    .in_service       (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Protocol model. Each source's history is a short window of sampled
  // values; the core-facing side is a phase counter: 0 nothing requested,
  // 1 waiting for accept, 2 being serviced, 3 mandatory quiet cycle.
  // ---------------------------------------------------------------------
  logic [N-1:0] m_hist [SYNC+1];   // m_hist[k] = irq_in sampled k+1 edges ago
  logic [N-1:0] m_pend;
  int           m_phase;
  int           m_grant;

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] lvl, rise_v, nxt;
    int           win;
    if (!rst_n) begin
      for (int k = 0; k <= SYNC; k++) m_hist[k] = '0;
      m_pend  = '0;
      m_phase = 0;
      m_grant = 0;
    end else begin
      lvl    = m_hist[SYNC-1];
      rise_v = m_hist[SYNC-1] & ~m_hist[SYNC];
      win    = lowest_set(m_pend & ~int_mask);
      nxt    = m_pend;
      for (int i = 0; i < N; i++) begin
        if (edge_sel[i]) begin
          if (m_phase == 2 && intering && i == m_grant) nxt[i] = 1'b0;
          if (rise_v[i]) nxt[i] = 1'b1;
        end else begin
          nxt[i] = lvl[i];
        end
      end
      case (m_phase)
        0: if (win >= 0) begin m_grant = win; m_phase = 1; end
        1: begin
          if (la_ta_ask) m_phase = 2;
`ifdef EXT_INT_CTRL_PREEMPT_EN
          else if (win >= 0 && win < m_grant) m_grant = win;
`endif
        end
        2: if (intering) m_phase = 3;
        default: m_phase = 0;
      endcase
      m_pend = nxt;
      for (int k = SYNC; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq_in;
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("model_sign", 32'(sign), 32'(m_phase == 1));
      if (m_phase == 1) check("model_num", 32'(num), 32'((32'(BASE) + m_grant) % 256));
      check("model_in_service", 32'(in_service), (m_phase == 2) ? (32'd1 << m_grant) : 32'd0);
      check("model_pending", 32'(pending), 32'(m_pend));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_irq(input logic [N-1:0] v);
    irq_in = v;
    cyc();
    cyc();
    irq_in = '0;
  endtask

  task automatic wait_sign(input int max, input string nm);
    int n = 0;
    while (sign !== 1'b1 && n < max) begin
      cyc();
      n++;
    end
    check(nm, 32'(sign), 32'd1);
  endtask

  task automatic serve();
    la_ta_ask = 1'b1;
    cyc();
    la_ta_ask = 1'b0;
    intering  = 1'b1;
    cyc();
    intering  = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    irq_in    = '0;
    edge_sel  = '1;
    int_mask  = '0;
    la_ta_ask = 1'b0;
    intering  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sign", 32'(sign), 32'd0);
    check("reset_num", 32'(num), 32'd0);
    check("reset_in_service", 32'(in_service), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc();

    // Stray handshake signals while idle are ignored.
    la_ta_ask = 1'b1;
    intering  = 1'b1;
    cyc();
    la_ta_ask = 1'b0;
    intering  = 1'b0;
    cyc();
    check("stray_sign", 32'(sign), 32'd0);

    // Single edge on source 3: request on the 4th edge after the input rises.
    irq_in[3] = 1'b1;
    cyc();
    cyc();
    irq_in[3] = 1'b0;
    cyc();
    check("single_lat3_sign", 32'(sign), 32'd0);
    cyc();
    check("single_lat4_sign", 32'(sign), 32'd1);
    check("single_num", 32'(num), 32'h23);
    la_ta_ask = 1'b1;
    cyc();
    la_ta_ask = 1'b0;
    check("single_acc_sign", 32'(sign), 32'd0);
    check("single_in_service", 32'(in_service), 32'h08);
    intering = 1'b1;
    cyc();
    intering = 1'b0;
    check("single_gap_pending", 32'(pending), 32'h00);
    check("single_gap_in_service", 32'(in_service), 32'h00);
    cyc();
    cyc();
    check("single_idle_sign", 32'(sign), 32'd0);

    // Priority: sources 5 and 1 together; 1 first, 5 after the gap.
    pulse_irq(8'h22);
    wait_sign(6, "prio_first_sign");
    check("prio_first_num", 32'(num), 32'h21);
    la_ta_ask = 1'b1;
    cyc();
    la_ta_ask = 1'b0;
    check("prio_in_service", 32'(in_service), 32'h02);
    intering = 1'b1;
    cyc();
    intering = 1'b0;
    check("prio_gap_sign", 32'(sign), 32'd0);
    check("prio_gap_pending", 32'(pending), 32'h20);
    cyc();
    check("prio_idle_sign", 32'(sign), 32'd0);
    cyc();
    check("prio_second_sign", 32'(sign), 32'd1);
    check("prio_second_num", 32'(num), 32'h25);
    serve();

    // Mask: pending latches but no request until the mask clears.
    int_mask = 8'h04;
    pulse_irq(8'h04);
    repeat (4) cyc();
    check("mask_pending", 32'(pending), 32'h04);
    check("mask_sign", 32'(sign), 32'd0);
    int_mask = 8'h00;
    cyc();
    check("unmask_sign", 32'(sign), 32'd1);
    check("unmask_num", 32'(num), 32'h22);
    serve();

    // Level source 0: re-requests while high; dropping it in REQ keeps sign.
    edge_sel  = 8'hFE;
    irq_in[0] = 1'b1;
    wait_sign(6, "level_first_sign");
    check("level_first_num", 32'(num), 32'h20);
    la_ta_ask = 1'b1;
    cyc();
    la_ta_ask = 1'b0;
    check("level_in_service", 32'(in_service), 32'h01);
    intering = 1'b1;
    cyc();
    intering = 1'b0;
    cyc();
    cyc();
    check("level_rerequest_sign", 32'(sign), 32'd1);
    check("level_rerequest_num", 32'(num), 32'h20);
    irq_in[0] = 1'b0;
    repeat (4) cyc();
    check("level_drop_sign", 32'(sign), 32'd1);
    check("level_drop_pending", 32'(pending), 32'h00);
    serve();
    repeat (2) cyc();
    check("level_done_sign", 32'(sign), 32'd0);
    edge_sel = 8'hFF;

    // New edge on the granted source in the retirement cycle: set wins.
    pulse_irq(8'h08);
    wait_sign(6, "setwin_sign");
    la_ta_ask = 1'b1;
    cyc();
    la_ta_ask = 1'b0;
    irq_in[3] = 1'b1;
    cyc();
    cyc();
    intering = 1'b1;
    cyc();
    intering  = 1'b0;
    irq_in[3] = 1'b0;
    check("setwin_pending", 32'(pending), 32'h08);
    cyc();
    cyc();
    check("setwin_rerequest_sign", 32'(sign), 32'd1);
    check("setwin_rerequest_num", 32'(num), 32'h23);
    serve();

    // Reset while the core is servicing source 4.
    pulse_irq(8'h10);
    wait_sign(6, "rst_req_sign");
    la_ta_ask = 1'b1;
    cyc();
    la_ta_ask = 1'b0;
    check("rst_in_service_before", 32'(in_service), 32'h10);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sign", 32'(sign), 32'd0);
    check("rst_mid_num", 32'(num), 32'd0);
    check("rst_mid_in_service", 32'(in_service), 32'd0);
    check("rst_mid_pending", 32'(pending), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) cyc();
    check("rst_after_sign", 32'(sign), 32'd0);

    // Higher-priority arrival while waiting for accept.
    pulse_irq(8'h40);
    wait_sign(6, "pre_first_sign");
    check("pre_first_num", 32'(num), 32'h26);
    pulse_irq(8'h02);
    repeat (3) cyc();
    check("pre_hold_sign", 32'(sign), 32'd1);
`ifdef EXT_INT_CTRL_PREEMPT_EN
    check("pre_num", 32'(num), 32'h21);
`else
    check("pre_num", 32'(num), 32'h26);
`endif
    serve();
    wait_sign(6, "pre_second_sign");
`ifdef EXT_INT_CTRL_PREEMPT_EN
    check("pre_second_num", 32'(num), 32'h26);
`else
    check("pre_second_num", 32'(num), 32'h21);
`endif
    serve();
    repeat (3) cyc();
    check("final_sign", 32'(sign), 32'd0);
    check("final_pending", 32'(pending), 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
